uart_tx_feeder: RTL and testbench
=================================

Name: uart_tx_feeder

Overview:
- Byte FIFO plus handshake sequencer that sits directly upstream of the UART transmitter.
- Accepts bytes from debug/status logic (e.g. edge-detector statistics) at any rate up to one per clock.
- Presents them one at a time to the transmitter using its tx_req / tx_valid / tx_busy handshake.
- Optionally inserts an idle gap between frames.

Parameters:
- AW, 4, FIFO address width; depth = 2^AW entries (16).
- GAP_CYCLES, 0, extra idle clocks enforced after the transmitter drops tx_busy before the next byte is offered; 0 = no gap.
- WDT_CYCLES, 64, watchdog limit in clocks; used only when the optional feature is compiled in.

Ports:
- clk  in  1  system clock (27 MHz domain shared with transmitter)
- rst  in  1  asynchronous active-high reset
- wr_data  in  8  byte to enqueue
- wr_en  in  1  enqueue strobe, one byte per cycle while high
- full  out  1  FIFO holds 2^AW bytes
- empty  out  1  FIFO holds 0 bytes
- level  out  AW+1  current FIFO occupancy, 0..2^AW
- ovf  out  1  one-cycle pulse when wr_en is asserted while full; the byte is dropped
- tx_req  in  1  transmitter ready request (level)
- tx_busy  in  1  transmitter frame in progress
- tx_data  out  8  byte to transmitter, held stable from tx_valid until next pop
- tx_valid  out  1  one-cycle strobe accepting tx_data
- wdt_err  out  1  one-cycle pulse on watchdog expiry (feature only; tied 0 otherwise)

Behaviour:
- Reset values: full=0, empty=1, level=0, ovf=0, tx_data=0, tx_valid=0, wdt_err=0. FSM in IDLE; read/write pointers 0; gap counter 0.
- FIFO: registered outputs; write at wr_ptr on wr_en & ~full.
- Read is a pop by the FSM, with data registered into tx_data one cycle later.
- Simultaneous write and pop: level unchanged. Write while full: dropped, ovf pulses. Pointers wrap modulo 2^AW.
- FSM states:
  - IDLE: go to POP when ~empty & tx_req & ~tx_busy & gap counter == 0.
  - POP: assert internal read; pointer advances, level decrements. Go to SEND.
  - SEND: tx_data now holds the popped byte; tx_valid=1 for exactly this cycle. Go to WAIT_BUSY.
  - WAIT_BUSY: wait for tx_busy=1; the transmitter raises it 1–2 clocks after tx_valid. On tx_busy go to WAIT_DONE. tx_req is ignored here because the transmitter's tx_req stays high for up to 2 clocks after tx_valid.
  - WAIT_DONE: wait for tx_busy=0. Then load the gap counter with GAP_CYCLES and go to IDLE.
- Gap counter: decrements by 1 each clock in IDLE while nonzero. With GAP_CYCLES=0 the next byte's POP can occur on the cycle after tx_busy falls, provided tx_req is high.
- Latency: byte written into an empty FIFO with the transmitter idle → tx_valid 3 clocks after the wr_en cycle (write, IDLE→POP, POP→SEND).
- A byte written in the same cycle the FIFO becomes nonempty is not readable until the next cycle (empty is registered).
- tx_valid is never asserted twice for the same byte and never asserted outside SEND.
- Asynchronous rst mid-frame: FIFO contents discarded, FSM to IDLE, tx_valid forced 0 immediately. The transmitter finishes its current frame independently; the feeder waits for tx_busy=0 before the next POP.
- level width AW+1 so that full (2^AW) is representable; full = (level == 2^AW).

Optional Feature:
- Macro UART_FEEDER_WDT_EN.
- When defined: a counter runs in WAIT_BUSY. If tx_busy is not seen within WDT_CYCLES clocks of SEND, the FSM returns to IDLE, wdt_err pulses for one cycle, and the byte is lost (not re-queued).
- Without the macro: WAIT_BUSY waits indefinitely, the counter logic is absent, and wdt_err is tied 0.

Test Plan:
- Reset, then write 0xA5 to an idle transmitter model (tx_req=1, tx_busy rises 2 clocks after tx_valid and stays high 1000 clocks) → tx_valid single pulse 3 clocks after wr_en with tx_data=0xA5; level returns to 0.
- Burst 16 writes 0x00..0x0F with the transmitter held busy, then a 17th write 0xFF → full=1, level=16, ovf pulses once. Release → bytes 0x00..0x0F emerge in order; 0xFF never emerges.
- GAP_CYCLES=5, two queued bytes → second tx_valid occurs no earlier than 5+2 clocks after tx_busy falls for the first frame.
- Simultaneous wr_en and POP at level=1 → level stays 1; subsequent byte ordering correct.
- Assert rst while WAIT_DONE with 3 bytes queued → empty=1, level=0, tx_valid=0. The next written byte 0x3C is sent only after the model's tx_busy drops.
- With UART_FEEDER_WDT_EN, WDT_CYCLES=64, model never raises tx_busy → wdt_err pulses 64 clocks after tx_valid. The next queued byte is offered afterwards.

Source files
------------

// File: rtl/uart_tx_feeder.sv
// Byte FIFO and tx_req/tx_valid/tx_busy sequencer feeding the UART transmitter.
// Define UART_FEEDER_WDT_EN to add a watchdog that abandons a byte the transmitter never takes.
module uart_tx_feeder #(
    parameter int unsigned AW         = 4,
    parameter int unsigned GAP_CYCLES = 0,
    parameter int unsigned WDT_CYCLES = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    wr_data,
    input  logic          wr_en,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level,
    output logic          ovf,
    input  logic          tx_req,
    input  logic          tx_busy,
    output logic [7:0]    tx_data,
    output logic          tx_valid,
    output logic          wdt_err
);

    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned GW    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_POP       = 3'd1;
    localparam logic [2:0] S_SEND      = 3'd2;
    localparam logic [2:0] S_WAIT_BUSY = 3'd3;
    localparam logic [2:0] S_WAIT_DONE = 3'd4;

    // The watchdog expiry compare needs at least two clocks of budget.
    if (WDT_CYCLES < 2) begin : g_wdt_chk
        $error("WDT_CYCLES must be at least 2");
    end

    logic [2:0]    state_q, state_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   level_q, level_d;
    logic          full_q, empty_q, ovf_q, tx_valid_q;
    logic [7:0]    tx_data_q;
    logic [7:0]    mem_q [DEPTH];
    logic          push, pop;

`ifdef UART_FEEDER_WDT_EN
    localparam int unsigned WW = $clog2(WDT_CYCLES + 1);
    logic [WW-1:0] wdt_q, wdt_d;
    logic          wdt_err_q, wdt_err_d;
`endif

    assign push = wr_en & ~full_q;
    assign pop  = (state_q == S_POP);

    // Occupancy next value; a simultaneous push and pop cancel out.
    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
    end

    // Next-state logic for the transmit handshake sequencer.
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
`ifdef UART_FEEDER_WDT_EN
        wdt_d     = wdt_q;
        wdt_err_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (gap_q != '0) begin
                    gap_d = gap_q - GW'(1);
                end else if (~empty_q & tx_req & ~tx_busy) begin
                    state_d = S_POP;
                end
            end
            S_POP:  state_d = S_SEND;
            S_SEND: begin
                state_d = S_WAIT_BUSY;
`ifdef UART_FEEDER_WDT_EN
                wdt_d = '0;
`endif
            end
            // tx_req is deliberately ignored here: it lingers high briefly after tx_valid.
            S_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = S_WAIT_DONE;
                end
`ifdef UART_FEEDER_WDT_EN
                else if (wdt_q == WW'(WDT_CYCLES - 2)) begin
                    state_d   = S_IDLE;
                    wdt_err_d = 1'b1;
                end else begin
                    wdt_d = wdt_q + WW'(1);
                end
`endif
            end
            S_WAIT_DONE: begin
                if (~tx_busy) begin
                    gap_d   = GW'(GAP_CYCLES);
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            gap_q   <= '0;
`ifdef UART_FEEDER_WDT_EN
            wdt_q     <= '0;
            wdt_err_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
`ifdef UART_FEEDER_WDT_EN
            wdt_q     <= wdt_d;
            wdt_err_q <= wdt_err_d;
`endif
        end
    end

    // FIFO bookkeeping and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            ovf_q      <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            level_q    <= level_d;
            full_q     <= (level_d == (AW+1)'(DEPTH));
            empty_q    <= (level_d == '0);
            ovf_q      <= wr_en & full_q;
            tx_valid_q <= (state_d == S_SEND);
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q  <= rd_ptr_q + AW'(1);
                tx_data_q <= mem_q[rd_ptr_q];
            end
        end
    end

    // Storage array carries no reset; occupancy tracking makes stale entries unreachable.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign full     = full_q;
    assign empty    = empty_q;
    assign level    = level_q;
    assign ovf      = ovf_q;
    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
`ifdef UART_FEEDER_WDT_EN
    assign wdt_err  = wdt_err_q;
`else
    assign wdt_err  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed self-checking bench for uart_tx_feeder with a simple transmitter model.
module tb_uart_tx_feeder;

    localparam int unsigned AW  = 4;
    localparam int unsigned GAP = 5;
    localparam int unsigned WDT = 64;

    logic          clk;
    logic          rst;
    logic [7:0]    wr_data;
    logic          wr_en;
    logic          full;
    logic          empty;
    logic [AW:0]   level;
    logic          ovf;
    logic          tx_req;
    logic          tx_busy;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          wdt_err;

    logic hold_busy  = 1'b0;
    logic model_busy = 1'b0;
    logic never_busy = 1'b0;
    assign tx_busy = hold_busy | model_busy;

    int n_vec = 0;
    int n_err = 0;

    int cyc       = 0;
    int rise_cnt  = 0;
    int busy_cnt  = 0;
    int busy_len  = 1000;
    int fall_cyc  = 0;
    int ovf_cnt   = 0;
    int wdt_cnt   = 0;
    int wdt_cyc   = 0;
    int dbl_cnt   = 0;
    logic prev_valid = 1'b0;
    logic [7:0] rx_q[$];
    int         vcyc_q[$];

    uart_tx_feeder #(.AW(AW), .GAP_CYCLES(GAP), .WDT_CYCLES(WDT)) dut (
        .clk(clk), .rst(rst), .wr_data(wr_data), .wr_en(wr_en),
        .full(full), .empty(empty), .level(level), .ovf(ovf),
        .tx_req(tx_req), .tx_busy(tx_busy), .tx_data(tx_data),
        .tx_valid(tx_valid), .wdt_err(wdt_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic write_byte(input logic [7:0] d);
        wr_data = d;
        wr_en   = 1'b1;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic wait_rx(input int n, input int budget, input string tag);
        int k = 0;
        while (rx_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk(tag, 32'(rx_q.size()), 32'(n));
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int k = 0;
        while ((model_busy || rise_cnt != 0) && k < budget) begin
            tick();
            k++;
        end
        chk(tag, 32'(model_busy), 32'(0));
    endtask

    // Transmitter model: busy rises 2 clocks after tx_valid, stays up busy_len clocks.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (rise_cnt > 0) begin
                rise_cnt--;
                if (rise_cnt == 0) begin
                    model_busy = 1'b1;
                    busy_cnt   = busy_len;
                end
            end else if (model_busy) begin
                busy_cnt--;
                if (busy_cnt == 0) begin
                    model_busy = 1'b0;
                    fall_cyc   = cyc;
                end
            end
            if (tx_valid) begin
                if (prev_valid) dbl_cnt++;
                rx_q.push_back(tx_data);
                vcyc_q.push_back(cyc);
                if (!never_busy) rise_cnt = 2;
            end
            prev_valid = tx_valid;
            if (ovf) ovf_cnt++;
            if (wdt_err) begin
                wdt_cnt++;
                wdt_cyc = cyc;
            end
        end
    end

    initial begin
        int base;
        int delta;
        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        tx_req  = 1'b1;
        tick();
        tick();
        chk("rst_full",     32'(full),     32'(0));
        chk("rst_empty",    32'(empty),    32'(1));
        chk("rst_level",    32'(level),    32'(0));
        chk("rst_ovf",      32'(ovf),      32'(0));
        chk("rst_tx_data",  32'(tx_data),  32'(0));
        chk("rst_tx_valid", 32'(tx_valid), 32'(0));
        chk("rst_wdt_err",  32'(wdt_err),  32'(0));
        rst = 1'b0;
        tick();

        // Single byte latency.
        base = rx_q.size();
        write_byte(8'hA5);
        chk("t1_level1", 32'(level), 32'(1));
        chk("t1_empty0", 32'(empty), 32'(0));
        tick();
        chk("t1_valid_c2", 32'(tx_valid), 32'(0));
        tick();
        chk("t1_valid_c3", 32'(tx_valid), 32'(1));
        chk("t1_data",     32'(tx_data),  32'(8'hA5));
        tick();
        chk("t1_valid_c4", 32'(tx_valid), 32'(0));
        chk("t1_level0",   32'(level),    32'(0));
        chk("t1_rx_cnt",   32'(rx_q.size()), 32'(base + 1));
        wait_idle(1100, "t1_idle");
        repeat (10) tick();

        // Fill to full, overflow once, then drain in order.
        busy_len  = 10;
        hold_busy = 1'b1;
        base = rx_q.size();
        for (int i = 0; i < 16; i++) begin
            wr_data = 8'(i);
            wr_en   = 1'b1;
            tick();
        end
        wr_data = 8'hFF;
        tick();
        wr_en = 1'b0;
        tick();
        chk("t2_full",    32'(full),  32'(1));
        chk("t2_level",   32'(level), 32'(16));
        chk("t2_ovf_cnt", 32'(ovf_cnt), 32'(1));
        chk("t2_ovf_low", 32'(ovf),   32'(0));
        chk("t2_no_tx",   32'(rx_q.size()), 32'(base));
        hold_busy = 1'b0;
        wait_rx(base + 16, 800, "t2_drain");
        for (int i = 0; i < 16; i++) begin
            chk("t2_order", 32'(rx_q[base + i]), 32'(i));
        end
        wait_idle(100, "t2_idle");
        repeat (30) tick();
        chk("t2_no_ff", 32'(rx_q.size()), 32'(base + 16));
        chk("t2_empty", 32'(empty), 32'(1));

        // Write in the same cycle as the pop at level 1.
        base = rx_q.size();
        hold_busy = 1'b1;
        write_byte(8'h11);
        chk("t3_level_pre", 32'(level), 32'(1));
        hold_busy = 1'b0;
        tick();
        chk("t3_level_pop", 32'(level), 32'(1));
        wr_data = 8'h22;
        wr_en   = 1'b1;
        tick();
        wr_en = 1'b0;
        chk("t3_level_same", 32'(level),    32'(1));
        chk("t3_valid",      32'(tx_valid), 32'(1));
        chk("t3_data0",      32'(tx_data),  32'(8'h11));
        wait_rx(base + 2, 100, "t3_rx");
        chk("t3_data1", 32'(rx_q[base + 1]), 32'(8'h22));
        wait_idle(100, "t3_idle");
        repeat (10) tick();

        // Async reset while the transmitter is mid-frame with bytes still queued.
        busy_len  = 1000;
        base = rx_q.size();
        hold_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr_data = 8'(8'h41 + i);
            wr_en   = 1'b1;
            tick();
        end
        wr_en = 1'b0;
        hold_busy = 1'b0;
        wait_rx(base + 1, 20, "t4_first");
        chk("t4_first_data", 32'(rx_q[base]), 32'(8'h41));
        repeat (5) tick();
        chk("t4_level3", 32'(level), 32'(3));
        rst = 1'b1;
        #1;
        chk("t4_rst_valid", 32'(tx_valid), 32'(0));
        chk("t4_rst_empty", 32'(empty),    32'(1));
        chk("t4_rst_level", 32'(level),    32'(0));
        tick();
        rst = 1'b0;
        write_byte(8'h3C);
        chk("t4_level1", 32'(level), 32'(1));
        wait_idle(1100, "t4_idle");
        chk("t4_held", 32'(rx_q.size()), 32'(base + 1));
        wait_rx(base + 2, 20, "t4_after");
        chk("t4_data", 32'(rx_q[base + 1]), 32'(8'h3C));
        wait_idle(1100, "t4_idle2");
        repeat (10) tick();
        chk("t4_no_stale", 32'(rx_q.size()), 32'(base + 2));

        // Inter-frame gap.
        busy_len  = 10;
        base = rx_q.size();
        hold_busy = 1'b1;
        write_byte(8'h51);
        write_byte(8'h52);
        hold_busy = 1'b0;
        wait_rx(base + 2, 100, "t5_rx");
        delta = vcyc_q[base + 1] - fall_cyc;
        chk("t5_gap_min", 32'(delta >= int'(GAP + 2)), 32'(1));
        chk("t5_data0", 32'(rx_q[base]),     32'(8'h51));
        chk("t5_data1", 32'(rx_q[base + 1]), 32'(8'h52));
        wait_idle(100, "t5_idle");
        repeat (10) tick();

`ifdef UART_FEEDER_WDT_EN
        // Transmitter never responds: watchdog drops the byte and moves on.
        begin
            int k;
            never_busy = 1'b1;
            base = rx_q.size();
            write_byte(8'h61);
            write_byte(8'h62);
            k = 0;
            while (wdt_cnt < 1 && k < 200) begin
                tick();
                k++;
            end
            chk("t6_wdt_seen",  32'(wdt_cnt), 32'(1));
            chk("t6_wdt_delay", 32'(wdt_cyc - vcyc_q[base]), 32'(WDT));
            wait_rx(base + 2, 20, "t6_next");
            chk("t6_data", 32'(rx_q[base + 1]), 32'(8'h62));
            k = 0;
            while (wdt_cnt < 2 && k < 200) begin
                tick();
                k++;
            end
            chk("t6_wdt_two", 32'(wdt_cnt), 32'(2));
            never_busy = 1'b0;
        end
`else
        chk("wdt_quiet", 32'(wdt_cnt), 32'(0));
`endif
        chk("no_double_valid", 32'(dbl_cnt), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
